prism_in_cond: RTL and testbench



---
 rtl/prism_in_cond.sv | 142 ++++++++++++++
 tb/tb_prism_in_cond.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prism_in_cond.sv
// Input conditioner for the PRISM in_data bus: per-channel debounce on a shared
// prescaled tick, clean levels, edge pulses, sticky edge flags and a maskable irq.
module prism_in_cond #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             irq
);

    logic [PRE_W-1:0] r_prescale;
    logic [PRE_W-1:0] r_pcnt;
    logic [3:0]       r_thresh;
    logic [1:0]       r_irqen;
    logic [WIDTH-1:0] r_din_q;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] r_dout_d;
    logic [WIDTH-1:0] r_rise_p;
    logic [WIDTH-1:0] r_fall_p;
    logic [WIDTH-1:0] r_rise_f;
    logic [WIDTH-1:0] r_fall_f;
    logic             r_irq;
    logic [3:0]       r_cnt [WIDTH];

    logic             w_tick;
    logic             w_wr_pre;
    logic             w_wr_thr;
    logic             w_wr_flags;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_clr_rise;
    logic [WIDTH-1:0] w_clr_fall;
    logic             w_unused;

    assign w_tick     = (r_pcnt == r_prescale);
    assign w_wr_pre   = cfg_wr && (cfg_addr == 2'd0);
    assign w_wr_thr   = cfg_wr && (cfg_addr == 2'd1);
    assign w_wr_flags = cfg_wr && (cfg_addr == 2'd2);
    assign w_wr_en    = cfg_wr && (cfg_addr == 2'd3);
    assign w_clr_rise = w_wr_flags ? cfg_wdata[WIDTH-1:0]   : '0;
    assign w_clr_fall = w_wr_flags ? cfg_wdata[16 +: WIDTH] : '0;
    assign w_unused   = ^cfg_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescale <= '0;
            r_pcnt     <= '0;
            r_thresh   <= 4'd2;
            r_irqen    <= 2'b00;
        end else begin
            if (w_wr_pre) begin
                r_prescale <= cfg_wdata[PRE_W-1:0];
            end
            if (w_wr_thr) begin
                r_thresh <= cfg_wdata[3:0];
            end
            if (w_wr_en) begin
                r_irqen <= cfg_wdata[1:0];
            end
            // A prescale write restarts the tick phase so the new period starts clean.
            if (w_wr_pre || w_tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_din_q <= '0;
            r_dout  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_din_q <= din;
            for (int i = 0; i < WIDTH; i++) begin
                if (r_din_q[i] == r_dout[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_thresh == 4'd0) begin
                    r_dout[i] <= r_din_q[i];
                end else if (w_tick) begin
                    // >= lets a lowered threshold qualify a long-running count at once.
                    if (({1'b0, r_cnt[i]} + 5'd1) >= {1'b0, r_thresh}) begin
                        r_dout[i] <= r_din_q[i];
                        r_cnt[i]  <= '0;
                    end else if (r_cnt[i] != 4'hF) begin
                        r_cnt[i] <= r_cnt[i] + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout_d <= '0;
            r_rise_p <= '0;
            r_fall_p <= '0;
            r_rise_f <= '0;
            r_fall_f <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_dout_d <= r_dout;
            r_rise_p <= r_dout & ~r_dout_d;
            r_fall_p <= ~r_dout & r_dout_d;
            // A new edge in the same cycle as its clear keeps the flag set.
            r_rise_f <= (r_rise_f & ~w_clr_rise) | r_rise_p;
            r_fall_f <= (r_fall_f & ~w_clr_fall) | r_fall_p;
            r_irq    <= (|(r_rise_f & {WIDTH{r_irqen[0]}})) |
                        (|(r_fall_f & {WIDTH{r_irqen[1]}}));
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            2'd0: cfg_rdata[PRE_W-1:0] = r_prescale;
            2'd1: cfg_rdata[3:0] = r_thresh;
            2'd2: begin
                cfg_rdata[WIDTH-1:0]   = r_rise_f;
                cfg_rdata[16 +: WIDTH] = r_fall_f;
            end
            default: cfg_rdata[1:0] = r_irqen;
        endcase
    end

    assign dout       = r_dout;
    assign rise_pulse = r_rise_p;
    assign fall_pulse = r_fall_p;
    assign irq        = r_irq;

endmodule

// File: tb/tb_prism_in_cond.sv
// Bench for prism_in_cond: directed scenarios with fixed expectations, then a
// randomized run compared against a rule-level model of the conditioner.
module tb_prism_in_cond;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [31:0] cfg_wdata = 32'h0;
    logic [31:0] cfg_rdata;
    logic [7:0]  dout;
    logic [7:0]  rise_pulse;
    logic [7:0]  fall_pulse;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    prism_in_cond #(.WIDTH(8), .PRE_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .dout       (dout),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model: levels, disagreement run lengths in ticks, and the
    // prescaler phase as cycles elapsed since the last period (re)start.
    logic [7:0] m_seen, m_lvl, m_chg, m_rose, m_fell, m_rise_f, m_fall_f;
    logic       m_irq;
    logic [1:0] m_en;
    int         m_thr, m_pre, m_age;
    int         m_run [8];
    logic       mt_tick, mt_irq;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_seen = '0; m_lvl = '0; m_chg = '0; m_rose = '0; m_fell = '0;
            m_rise_f = '0; m_fall_f = '0; m_irq = 1'b0; m_en = 2'b00;
            m_thr = 2; m_pre = 0; m_age = 0;
            for (int i = 0; i < 8; i++) m_run[i] = 0;
        end else begin
            mt_tick = ((m_age % (m_pre + 1)) == m_pre);
            mt_irq  = (|(m_rise_f & {8{m_en[0]}})) || (|(m_fall_f & {8{m_en[1]}}));
            if (cfg_wr && cfg_addr == 2'd2) begin
                m_rise_f = m_rise_f & ~cfg_wdata[7:0];
                m_fall_f = m_fall_f & ~cfg_wdata[23:16];
            end
            m_rise_f = m_rise_f | m_rose;
            m_fall_f = m_fall_f | m_fell;
            m_irq    = mt_irq;
            m_rose   = m_chg & m_lvl;
            m_fell   = m_chg & ~m_lvl;
            m_chg    = '0;
            for (int i = 0; i < 8; i++) begin
                if (m_seen[i] == m_lvl[i]) m_run[i] = 0;
                else if (m_thr == 0) m_chg[i] = 1'b1;
                else if (mt_tick) begin
                    if (m_run[i] + 1 >= m_thr) begin
                        m_chg[i] = 1'b1;
                        m_run[i] = 0;
                    end else begin
                        m_run[i] = (m_run[i] < 15) ? m_run[i] + 1 : 15;
                    end
                end
            end
            m_lvl  = m_lvl ^ m_chg;
            m_seen = din;
            m_age  = m_age + 1;
            if (cfg_wr) begin
                case (cfg_addr)
                    2'd0: begin m_pre = int'(cfg_wdata[15:0]); m_age = 0; end
                    2'd1: m_thr = int'(cfg_wdata[3:0]);
                    2'd3: m_en = cfg_wdata[1:0];
                    default: ;
                endcase
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rst = 1'b1; din = 8'h00;
        cycles(2);
        n_checks++; if (dout !== 8'h00) begin n_errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
        n_checks++; if ((rise_pulse | fall_pulse) !== 8'h00) begin n_errors++; $display("FAIL reset_pulses: got %h/%h expected 00/00", rise_pulse, fall_pulse); end
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        cfg_read(2'd0, rd);
        n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_prescale: got %h expected 00000000", rd); end
        cfg_read(2'd1, rd);
        n_checks++; if (rd !== 32'h2) begin n_errors++; $display("FAIL reset_thresh: got %h expected 00000002", rd); end
        cfg_read(2'd2, rd);
        n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_flags: got %h expected 00000000", rd); end
        cfg_read(2'd3, rd);
        n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_irqen: got %h expected 00000000", rd); end
        @(negedge clk);
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic test_bypass;
        logic [31:0] rd;
        cfg_write(2'd1, 32'h0);
        din = 8'h01;
        cycles(1);
        n_checks++; if (dout !== 8'h00) begin n_errors++; $display("FAIL bypass_early: got %h expected 00", dout); end
        cycles(1);
        n_checks++; if (dout !== 8'h01) begin n_errors++; $display("FAIL bypass_dout: got %h expected 01", dout); end
        n_checks++; if (rise_pulse !== 8'h00) begin n_errors++; $display("FAIL bypass_pulse_early: got %h expected 00", rise_pulse); end
        cycles(1);
        n_checks++; if (rise_pulse !== 8'h01) begin n_errors++; $display("FAIL bypass_pulse: got %h expected 01", rise_pulse); end
        cycles(1);
        n_checks++; if (rise_pulse !== 8'h00) begin n_errors++; $display("FAIL bypass_pulse_len: got %h expected 00", rise_pulse); end
        cfg_read(2'd2, rd);
        n_checks++; if (rd !== 32'h00000001) begin n_errors++; $display("FAIL bypass_flags: got %h expected 00000001", rd); end
        cfg_write(2'd2, 32'hFFFF_FFFF);
    endtask

    task automatic test_glitch;
        logic [31:0] rd;
        cfg_write(2'd1, 32'h3);
        din = 8'h05;
        cycles(2);
        din = 8'h01;
        cycles(6);
        n_checks++; if (dout !== 8'h01) begin n_errors++; $display("FAIL glitch_dout: got %h expected 01", dout); end
        cfg_read(2'd2, rd);
        n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL glitch_flags: got %h expected 00000000", rd); end
        din = 8'h05;
        cycles(3);
        n_checks++; if (dout !== 8'h01) begin n_errors++; $display("FAIL thresh3_early: got %h expected 01", dout); end
        cycles(1);
        n_checks++; if (dout !== 8'h05) begin n_errors++; $display("FAIL thresh3_dout: got %h expected 05", dout); end
        cycles(3);
        cfg_write(2'd2, 32'hFFFF_FFFF);
    endtask

    task automatic test_prescale;
        cfg_write(2'd1, 32'h2);
        cfg_write(2'd0, 32'h4);
        din = 8'h25;
        cycles(9);
        n_checks++; if (dout !== 8'h05) begin n_errors++; $display("FAIL presc_early: got %h expected 05", dout); end
        cycles(1);
        n_checks++; if (dout !== 8'h25) begin n_errors++; $display("FAIL presc_dout: got %h expected 25", dout); end
        din = 8'h05;
        cycles(3);
        cfg_write(2'd0, 32'h4);
        cycles(6);
        n_checks++; if (dout !== 8'h25) begin n_errors++; $display("FAIL phase_reset_old: got %h expected 25", dout); end
        cycles(3);
        n_checks++; if (dout !== 8'h25) begin n_errors++; $display("FAIL phase_reset_early: got %h expected 25", dout); end
        cycles(1);
        n_checks++; if (dout !== 8'h05) begin n_errors++; $display("FAIL phase_reset_dout: got %h expected 05", dout); end
        cfg_write(2'd0, 32'h0);
        cycles(3);
        cfg_write(2'd2, 32'hFFFF_FFFF);
    endtask

    task automatic test_irq;
        logic [31:0] rd;
        cfg_write(2'd3, 32'h2);
        din = 8'h85;
        cycles(8);
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_rise_masked: got %b expected 0", irq); end
        cfg_read(2'd2, rd);
        n_checks++; if (rd !== 32'h00000080) begin n_errors++; $display("FAIL irq_rise_flag: got %h expected 00000080", rd); end
        din = 8'h05;
        cycles(8);
        cfg_read(2'd2, rd);
        n_checks++; if (rd !== 32'h00800080) begin n_errors++; $display("FAIL irq_fall_flag: got %h expected 00800080", rd); end
        n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_fall: got %b expected 1", irq); end
        cfg_write(2'd2, 32'h00800000);
        cfg_read(2'd2, rd);
        n_checks++; if (rd !== 32'h00000080) begin n_errors++; $display("FAIL irq_clear_flag: got %h expected 00000080", rd); end
        n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_clear_lag: got %b expected 1", irq); end
        cycles(1);
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_cleared: got %b expected 0", irq); end
        cfg_write(2'd3, 32'h3);
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_enable_lag: got %b expected 0", irq); end
        cycles(1);
        n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_enable_pending: got %b expected 1", irq); end
        cfg_write(2'd3, 32'h0);
        cfg_write(2'd2, 32'hFFFF_FFFF);
    endtask

    task automatic test_set_wins;
        logic [31:0] rd;
        din = 8'h07;
        cycles(6);
        din = 8'h05;
        cycles(6);
        din = 8'h07;
        cycles(4);
        n_checks++; if (rise_pulse !== 8'h02) begin n_errors++; $display("FAIL setwins_pulse: got %h expected 02", rise_pulse); end
        cfg_write(2'd2, 32'h2);
        cfg_read(2'd2, rd);
        n_checks++; if (rd[1] !== 1'b1) begin n_errors++; $display("FAIL setwins_flag: got %b expected 1", rd[1]); end
        cfg_write(2'd2, 32'h2);
        cfg_read(2'd2, rd);
        n_checks++; if (rd[1] !== 1'b0) begin n_errors++; $display("FAIL setwins_clear: got %b expected 0", rd[1]); end
        cfg_write(2'd2, 32'hFFFF_FFFF);
    endtask

    task automatic test_async_reset;
        logic [31:0] rd;
        cfg_write(2'd1, 32'h3);
        din = 8'h0D;
        cycles(3);
        rst = 1'b1;
        #1;
        n_checks++; if (dout !== 8'h00) begin n_errors++; $display("FAIL areset_dout: got %h expected 00", dout); end
        cfg_read(2'd1, rd);
        n_checks++; if (rd !== 32'h2) begin n_errors++; $display("FAIL areset_thresh: got %h expected 00000002", rd); end
        cfg_read(2'd2, rd);
        n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL areset_flags: got %h expected 00000000", rd); end
        cycles(2);
        rst = 1'b0;
        cfg_wr = 1'b1; cfg_addr = 2'd1; cfg_wdata = 32'h3;
        @(negedge clk);
        cfg_wr = 1'b0;
        n_checks++; if ((rise_pulse | fall_pulse | dout) !== 8'h00) begin n_errors++; $display("FAIL release_quiet: got %h/%h/%h expected 00/00/00", rise_pulse, fall_pulse, dout); end
        cycles(2);
        n_checks++; if (dout !== 8'h00) begin n_errors++; $display("FAIL release_early: got %h expected 00", dout); end
        cycles(1);
        n_checks++; if (dout !== 8'h0D) begin n_errors++; $display("FAIL release_qualify: got %h expected 0d", dout); end
        cycles(1);
        n_checks++; if (rise_pulse !== 8'h0D) begin n_errors++; $display("FAIL release_pulse: got %h expected 0d", rise_pulse); end
    endtask

    task automatic test_random;
        logic [31:0] rd;
        int r;
        for (int it = 0; it < 600; it++) begin
            @(negedge clk);
            cfg_wr = 1'b0;
            n_checks++; if (dout !== m_lvl) begin n_errors++; $display("FAIL rand_dout it=%0d: got %h expected %h", it, dout, m_lvl); end
            n_checks++; if (rise_pulse !== m_rose) begin n_errors++; $display("FAIL rand_rise it=%0d: got %h expected %h", it, rise_pulse, m_rose); end
            n_checks++; if (fall_pulse !== m_fell) begin n_errors++; $display("FAIL rand_fall it=%0d: got %h expected %h", it, fall_pulse, m_fell); end
            n_checks++; if (irq !== m_irq) begin n_errors++; $display("FAIL rand_irq it=%0d: got %b expected %b", it, irq, m_irq); end
            cfg_read(2'd2, rd);
            n_checks++; if (rd !== {8'h00, m_fall_f, 8'h00, m_rise_f}) begin n_errors++; $display("FAIL rand_flags it=%0d: got %h expected %h", it, rd, {8'h00, m_fall_f, 8'h00, m_rise_f}); end
            r = $urandom_range(0, 19);
            case (r)
                0: begin cfg_wr = 1'b1; cfg_addr = 2'd1; cfg_wdata = $urandom_range(0, 4); end
                1: begin cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_wdata = $urandom_range(0, 3); end
                2: begin cfg_wr = 1'b1; cfg_addr = 2'd2; cfg_wdata = $urandom; end
                3: begin cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = $urandom_range(0, 3); end
                default: ;
            endcase
            if ($urandom_range(0, 6) == 0) din = din ^ 8'($urandom_range(1, 255));
        end
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bypass();
        test_glitch();
        test_prescale();
        test_irq();
        test_set_wins();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
